seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked successor to the datapath's combinational 2-bit-opcode ALU. Adds a WIDTH parameter, a 3-bit opcode with signed and unsigned compares, logical ops and an optional iterative multiplier. Uses valid/ready handshakes on input and output and registers results and flags. It sits between the register-read stage and writeback, and can stall the pipeline for multi-cycle operations.

## Interface
- WIDTH, 32: operand and result width in bits (≥4).
- CNT_W, $clog2(WIDTH)+1: multiply iteration counter width.

- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- InValid  in  1  operand/opcode presented.
- InReady  out  1  block can accept; a transfer occurs when InValid && InReady at a clk edge.
- BussA, BussB  in  WIDTH  operands.
- ALUControl  in  3  opcode: 000 ADD, 001 XOR, 010 SUB, 011 SLTU, 100 SLT (signed), 101 AND, 110 OR, 111 MUL.
- OutValid  out  1  Output and flags valid.
- OutReady  in  1  consumer accepts the result when OutValid && OutReady.
- Output  out  WIDTH  registered result.
- CarryOut, zero, overflow, negative  out  1 each  registered flags, aligned with Output.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- InReady = (state==IDLE) || (state==DONE && OutReady). OutValid = (state==DONE).
- Accepting a non-MUL op:
  - The result and flags are computed from the captured inputs and registered.
  - Next state is DONE.
- Accepting MUL:
  - Capture the multiplicand, the multiplier and a 2·WIDTH accumulator cleared to 0.
  - Go to BUSY with counter=0.
  - Each BUSY cycle does one shift-add step on multiplier bit [counter] and increments the counter.
  - After WIDTH steps, register the result and go to DONE.
- In DONE, when OutReady is high:
  - With a new transfer, go to the next op's path (back-to-back).
  - Otherwise go to IDLE.
- In DONE with OutReady low:
  - Output and flags hold stable.
  - No new op is accepted.
- Arithmetic is modulo 2^WIDTH.
- ADD: CarryOut = bit WIDTH of the (WIDTH+1)-bit sum. overflow = operands have the same sign and the result sign differs.
- SUB:
  - CarryOut = NOT borrow (1 when BussA ≥ BussB unsigned).
  - overflow = operands have different signs and the result sign differs from BussA.
- SLTU / SLT: Output = 1 or 0 (zero-extended) from an unsigned or two's-complement compare. CarryOut = 0, overflow = 0.
- XOR/AND/OR: CarryOut = 0, overflow = 0.
- MUL:
  - Output = low WIDTH bits of the unsigned product. CarryOut = 0.
  - overflow = 1 if any upper WIDTH product bit is nonzero.
- All ops: negative = Output[WIDTH-1]; zero = (Output == 0).
- InValid while InReady is low is ignored. The producer must hold its inputs.

## Timing
- Reset (async assert, sync-safe deassert):
  - state = IDLE; Output = 0.
  - CarryOut, zero, overflow, negative = 0.
  - Accumulator and counter = 0.
  - OutValid = 0 and InReady = 1 immediately.
- Non-MUL latency: OutValid rises the cycle after the accepting edge (1 cycle).
- MUL latency: WIDTH BUSY cycles, then DONE. OutValid is high WIDTH+1 cycles after the accepting edge.
- Throughput: one non-MUL op per cycle while OutReady stays high.
- Reset asserted mid-BUSY or in DONE aborts the op. The result is discarded, and the next op is accepted after deassertion.
- Changing an opcode or operand after acceptance has no effect on the in-flight op.

## Configuration
- SEQ_ALU_MUL_EN defined:
  - MUL behaves as above.
  - BUSY state, counter and accumulator are present.
- Not defined:
  - No multiplier logic is built.
  - Opcode 111 completes in 1 cycle with Output = 0 and zero = 1.
  - CarryOut, overflow and negative = 0.
  - The BUSY state is never entered.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001, WIDTH=32 -> Output 0x00000000, CarryOut=1, zero=1, overflow=0; OutValid on the next cycle.
- SUB 0x80000000 − 0x00000001 -> Output 0x7FFFFFFF, overflow=1, CarryOut=1, negative=0. SUB 1 − 2 -> 0xFFFFFFFF, CarryOut=0, negative=1.
- SLT 0xFFFFFFFF vs 0x00000001 -> Output 1. SLTU with the same operands -> Output 0. Both have CarryOut=0 and overflow=0.
- MUL (macro on) 0x00010000 × 0x00010000 -> Output 0, overflow=1, zero=1, OutValid at cycle 33. MUL 7 × 6 -> 42, overflow=0. With the macro off, MUL -> Output 0 after 1 cycle.
- Backpressure: issue ADD 3+4 with OutReady=0 for 5 cycles -> OutValid stays 1, Output holds 7, InReady=0. Then raise OutReady with InValid high and XOR 0xF0^0xFF -> Output 0x0F on the next cycle.
- Pull rst_n low in the 10th BUSY cycle of a MUL -> OutValid=0 and Output=0 immediately, InReady=1. The next ADD 1+1 after release -> Output 2.

Source files
------------

// File: rtl/seq_alu_if.sv
// seq_alu_if: valid/ready operand and result channels between a producer (master) and seq_alu (slave)
// Parameters:
//     WIDTH       operand and result width in bits
// Signals:
//     InValid     master -> slave   operand/opcode presented
//     InReady     slave  -> master  slave can accept this cycle
//     BussA/B     master -> slave   operands (WIDTH)
//     ALUControl  master -> slave   3-bit opcode
//     OutValid    slave  -> master  Output and flags valid
//     OutReady    master -> slave   consumer takes the result
//     Output      slave  -> master  registered result (WIDTH)
//     CarryOut, zero, overflow, negative  slave -> master  registered flags
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] BussA;
    logic [WIDTH-1:0] BussB;
    logic [2:0]       ALUControl;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Output;
    logic             CarryOut;
    logic             zero;
    logic             overflow;
    logic             negative;

    modport master (
        output InValid, BussA, BussB, ALUControl, OutReady,
        input  InReady, OutValid, Output, CarryOut, zero, overflow, negative
    );

    modport slave (
        input  InValid, BussA, BussB, ALUControl, OutReady,
        output InReady, OutValid, Output, CarryOut, zero, overflow, negative
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: handshaked WIDTH-bit ALU with registered result/flags and an optional iterative multiplier
// Build option:
//     SEQ_ALU_MUL_EN  when defined, opcode 111 runs a WIDTH-step shift-add multiply through BUSY;
//                     when undefined, opcode 111 completes in one cycle with Output=0, zero=1
// Parameters:
//     WIDTH  operand/result width (>= 4)
//     CNT_W  multiply step counter width
// Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    seq_alu_if.slave: operand channel (InValid/InReady, BussA, BussB, ALUControl)
//            and result channel (OutValid/OutReady, Output, CarryOut, zero, overflow, negative)
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic      clk,
    input logic      rst_n,
    seq_alu_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nx;
    logic             xfer, ld;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] res_c, res_ld, res;
    logic             cf_c, of_c, cf_ld, of_ld;
    logic             cf, zf, of, nf;
`ifdef SEQ_ALU_MUL_EN
    logic               is_mul, last;
    logic [2*WIDTH-1:0] mcand, acc, acc_nx;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
`endif

    if (WIDTH < 4 || CNT_W < $clog2(WIDTH) + 1) begin : g_cfg_check
        $error("seq_alu: WIDTH must be >= 4 and CNT_W >= $clog2(WIDTH)+1");
    end

    assign bus.InReady  = state == IDLE || (state == DONE && bus.OutReady);
    assign bus.OutValid = state == DONE;
    assign bus.Output   = res;
    assign bus.CarryOut = cf;
    assign bus.zero     = zf;
    assign bus.overflow = of;
    assign bus.negative = nf;
    assign xfer         = bus.InValid && bus.InReady;

`ifdef SEQ_ALU_MUL_EN
    assign is_mul = bus.ALUControl == 3'b111;
    // mcand is pre-shifted and mplier pre-shifted right, so bit 0 of mplier is bit [cnt] of the original
    assign acc_nx = acc + (mplier[0] ? mcand : '0);
    assign last   = cnt == CNT_W'(WIDTH - 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = xfer ? DONE : IDLE;
            DONE:    state_nx = xfer ? DONE : bus.OutReady ? IDLE : DONE;
`ifdef SEQ_ALU_MUL_EN
            BUSY:    state_nx = last ? DONE : BUSY;
`endif
            default: state_nx = IDLE;
        endcase
`ifdef SEQ_ALU_MUL_EN
        if (xfer && is_mul)
            state_nx = BUSY;
`endif
    end

    // single-cycle ops; opcode 111 falls to the all-zero default
    always_comb begin
        sum   = {1'b0, bus.BussA} + {1'b0, bus.BussB};
        diff  = {1'b0, bus.BussA} - {1'b0, bus.BussB};
        res_c = '0;
        cf_c  = 1'b0;
        of_c  = 1'b0;
        case (bus.ALUControl)
            3'b000: begin
                res_c = sum[MSB:0];
                cf_c  = sum[WIDTH];
                of_c  = bus.BussA[MSB] == bus.BussB[MSB] && sum[MSB] != bus.BussA[MSB];
            end
            3'b001: res_c = bus.BussA ^ bus.BussB;
            3'b010: begin
                res_c = diff[MSB:0];
                cf_c  = ~diff[WIDTH];
                of_c  = bus.BussA[MSB] != bus.BussB[MSB] && diff[MSB] != bus.BussA[MSB];
            end
            3'b011: res_c = {{MSB{1'b0}}, diff[WIDTH]};
            3'b100: res_c = {{MSB{1'b0}}, $signed(bus.BussA) < $signed(bus.BussB)};
            3'b101: res_c = bus.BussA & bus.BussB;
            3'b110: res_c = bus.BussA | bus.BussB;
            default: res_c = '0;
        endcase
    end

    // result register load: either an accepted single-cycle op or the final multiply step
    always_comb begin
        ld    = xfer;
        res_ld = res_c;
        cf_ld = cf_c;
        of_ld = of_c;
`ifdef SEQ_ALU_MUL_EN
        ld = (xfer && !is_mul) || (state == BUSY && last);
        if (state == BUSY) begin
            res_ld = acc_nx[MSB:0];
            cf_ld  = 1'b0;
            of_ld  = |acc_nx[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= '0;
            cf  <= 1'b0;
            zf  <= 1'b0;
            of  <= 1'b0;
            nf  <= 1'b0;
        end else if (ld) begin
            res <= res_ld;
            cf  <= cf_ld;
            zf  <= res_ld == '0;
            of  <= of_ld;
            nf  <= res_ld[MSB];
        end
    end

`ifdef SEQ_ALU_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (xfer && is_mul) begin
            mcand  <= {{WIDTH{1'b0}}, bus.BussA};
            mplier <= bus.BussB;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == BUSY) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: table-driven, hand-sequenced and randomized checks of seq_alu against a behavioural model
module tb_seq_alu;
    localparam int W = 32;
`ifdef SEQ_ALU_MUL_EN
    localparam int MUL_LAT = W;
`else
    localparam int MUL_LAT = 0;
`endif

    typedef struct packed {
        logic [31:0] out;
        logic        c, z, o, n;
    } res_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a, b;
        res_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs [13];

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t observed();
        res_t r;
        r = {bus.Output, bus.CarryOut, bus.zero, bus.overflow, bus.negative};
        return r;
    endfunction

    // reference: true-integer arithmetic; overflow means the exact result does not fit
    function automatic res_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t            e  = '0;
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint unsigned p  = 0;
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint          r  = 0;
        case (op)
            3'd0: begin p = ua + ub; e.out = p[31:0]; e.c = p[32]; r = sa + sb; end
            3'd1: e.out = a ^ b;
            3'd2: begin e.out = a - b; e.c = a >= b; r = sa - sb; end
            3'd3: e.out = {31'd0, a < b};
            3'd4: e.out = {31'd0, sa < sb};
            3'd5: e.out = a & b;
            3'd6: e.out = a | b;
            default: begin
`ifdef SEQ_ALU_MUL_EN
                p = ua * ub;
                e.out = p[31:0];
                e.o = p[63:32] != 32'd0;
`endif
            end
        endcase
        if (op == 3'd0 || op == 3'd2)
            e.o = r != longint'($signed(e.out));
        e.z = e.out == 32'd0;
        e.n = e.out[31];
        return e;
    endfunction

    // present an op, wait (bounded) for acceptance, then scramble the inputs
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        bus.InValid    = 1'b1;
        bus.ALUControl = op;
        bus.BussA      = a;
        bus.BussB      = b;
        while (!bus.InReady && n < 100) begin
            step();
            n++;
        end
        chk("in_ready_wait", {63'd0, bus.InReady}, 64'd1);
        step();
        bus.InValid    = 1'b0;
        bus.ALUControl = 3'($urandom);
        bus.BussA      = $urandom;
        bus.BussB      = $urandom;
    endtask

    task automatic wait_out(input string name, input int lat);
        int n = 0;
        while (!bus.OutValid && n < 100) begin
            step();
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'(lat));
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input res_t exp);
        issue(op, a, b);
        wait_out(name, op == 3'd7 ? MUL_LAT : 0);
        chk(name, 64'(observed()), 64'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = {3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1100};
        vecs[1]  = {3'd2, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b1010};
        vecs[2]  = {3'd2, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 4'b0001};
        vecs[3]  = {3'd4, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000};
        vecs[4]  = {3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0100};
        vecs[5]  = {3'd1, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F, 4'b0000};
        vecs[6]  = {3'd5, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 4'b0000};
        vecs[7]  = {3'd6, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 4'b0001};
        vecs[8]  = {3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0011};
        vecs[9]  = {3'd2, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1100};
`ifdef SEQ_ALU_MUL_EN
        vecs[10] = {3'd7, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b0110};
        vecs[11] = {3'd7, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 4'b0000};
        vecs[12] = {3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0010};
`else
        vecs[10] = {3'd7, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b0100};
        vecs[11] = {3'd7, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 4'b0100};
        vecs[12] = {3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0100};
`endif

        rst_n          = 1'b0;
        bus.InValid    = 1'b0;
        bus.BussA      = '0;
        bus.BussB      = '0;
        bus.ALUControl = '0;
        bus.OutReady   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {63'd0, bus.OutValid}, 64'd0);
        chk("reset_in_ready", {63'd0, bus.InReady}, 64'd1);
        chk("reset_result", 64'(observed()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 13; i++)
            run($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        // backpressure: result must hold and nothing new may enter while OutReady is low
        step();
        bus.OutReady = 1'b0;
        issue(3'd0, 32'd3, 32'd4);
        wait_out("bp_add", 0);
        bus.InValid    = 1'b1;
        bus.ALUControl = 3'd1;
        bus.BussA      = 32'h0000_00F0;
        bus.BussB      = 32'h0000_00FF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_out_valid", {63'd0, bus.OutValid}, 64'd1);
            chk("bp_hold", 64'(bus.Output), 64'd7);
            chk("bp_in_ready", {63'd0, bus.InReady}, 64'd0);
        end
        bus.OutReady = 1'b1;
        step();
        bus.InValid = 1'b0;
        chk("bp_xor_valid", {63'd0, bus.OutValid}, 64'd1);
        chk("bp_xor", 64'(bus.Output), 64'h0F);

        // reset in the 10th BUSY cycle of a multiply (or in DONE without the multiplier)
        step();
        issue(3'd7, 32'd5, 32'd9);
`ifdef SEQ_ALU_MUL_EN
        repeat (9) step();
        chk("busy_before_reset", {63'd0, bus.OutValid}, 64'd0);
`endif
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {63'd0, bus.OutValid}, 64'd0);
        chk("abort_in_ready", {63'd0, bus.InReady}, 64'd1);
        chk("abort_result", 64'(observed()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run("add_after_reset", 3'd0, 32'd1, 32'd1, {32'd2, 4'b0000});

        for (int i = 0; i < 200; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            res_t        e;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: a = a & 32'hF;
                1: b = a;
                2: a = {1'b1, 31'($urandom_range(0, 3))};
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            e = model(op, a, b);
            run("rand", op, a, b, e);
            if ($urandom_range(0, 3) == 0) begin
                bus.OutReady = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    step();
                    chk("rand_hold", 64'(observed()), 64'(e));
                    chk("rand_hold_in_ready", {63'd0, bus.InReady}, 64'd0);
                end
                bus.OutReady = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
